// File: rtl/csd_pkg.sv
// Shared CSD definitions: digit codes and the decoder state encoding.
package csd_pkg;

    localparam logic [1:0] CSD_ZERO = 2'b00;
    localparam logic [1:0] CSD_POS  = 2'b01;
    localparam logic [1:0] CSD_NEG  = 2'b11;
    localparam logic [1:0] CSD_ILL  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } csd_state_e;

    function automatic logic csd_nonzero(input logic [1:0] code);
        return (code == CSD_POS) || (code == CSD_NEG);
    endfunction

endpackage

// File: rtl/csd_digit_ram.sv
// N x 2-bit digit store: synchronous write, asynchronous read, out-of-range writes masked.
module csd_digit_ram
    import csd_pkg::*;
#(
    parameter int unsigned N  = 8,
    parameter int unsigned AW = 4
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [1:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [1:0]    rdata_o
);

    localparam int unsigned IW    = (N > 1) ? $clog2(N) : 1;
    localparam logic [AW:0] Depth = (AW + 1)'(N);

    logic [1:0] mem_q [N];
    logic       wr_ok;
    logic       rd_ok;

    assign wr_ok = ({1'b0, waddr_i} < Depth);
    assign rd_ok = ({1'b0, raddr_i} < Depth);

    // No reset: stored digits survive a decoder reset.
    always_ff @(posedge clk_i) begin
        if (we_i && wr_ok) begin
            mem_q[waddr_i[IW-1:0]] <= wdata_i;
        end
    end

    assign rdata_o = rd_ok ? mem_q[raddr_i[IW-1:0]] : CSD_ZERO;

endmodule

// File: rtl/csd_to_bin_decoder.sv
// Rebuilds a two's-complement value from N stored CSD digits, MSB first (acc = 2*acc + d).
module csd_to_bin_decoder
    import csd_pkg::*;
#(
    parameter int unsigned N  = 8,
    parameter int unsigned AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          weCsd,
    input  logic [AW-1:0] address,
    input  logic [1:0]    dataIn,
    output logic [N:0]    result,
    output logic          busy,
    output logic          done,
    output logic          notCanonical,
    output logic          illegalDigit
);

    csd_state_e    state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [N:0]    acc_q, acc_d;
    logic [N:0]    result_q, result_d;
    logic          prev_q, prev_d;
    logic          nc_q, nc_d;
    logic          ill_q, ill_d;

    logic [1:0]    rd_code;
    logic [N:0]    digit;
    logic          dig_nz;
    logic          dig_ill;
    logic          ram_we;

    assign ram_we = weCsd && (state_q != ST_RUN);

    csd_digit_ram #(
        .N  (N),
        .AW (AW)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .waddr_i (address),
        .wdata_i (dataIn),
        .raddr_i (idx_q),
        .rdata_o (rd_code)
    );

    always_comb begin
        digit   = '0;
        dig_ill = 1'b0;
        dig_nz  = csd_nonzero(rd_code);
        unique case (rd_code)
            CSD_ZERO: digit = '0;
            CSD_POS:  digit = {{N{1'b0}}, 1'b1};
            CSD_NEG:  digit = '1;
            CSD_ILL:  dig_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        result_d = result_q;
        prev_d   = prev_q;
        nc_d     = nc_q;
        ill_d    = ill_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    idx_d   = AW'(N - 1);
                    acc_d   = '0;
                    prev_d  = 1'b0;
                    nc_d    = 1'b0;
                    ill_d   = 1'b0;
                end
            end
            ST_RUN: begin
                acc_d  = {acc_q[N-1:0], 1'b0} + digit;
                nc_d   = nc_q | (dig_nz & prev_q);
                ill_d  = ill_q | dig_ill;
                prev_d = dig_nz;
                idx_d  = idx_q - AW'(1);
                if (idx_q == '0) begin
                    result_d = acc_d;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                // Holding start high must not retrigger; wait for it to drop.
                if (!start) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            prev_q   <= 1'b0;
            nc_q     <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            prev_q   <= prev_d;
            nc_q     <= nc_d;
            ill_q    <= ill_d;
        end
    end

    assign result       = result_q;
    assign busy         = (state_q == ST_RUN);
    assign done         = (state_q == ST_DONE);
    assign notCanonical = nc_q;
    assign illegalDigit = ill_q;

endmodule

// File: tb/tb_csd_to_bin_decoder.sv
// Bench for csd_to_bin_decoder: directed table plus random digits against a sum-of-powers model.
module tb_csd_to_bin_decoder;
    import csd_pkg::*;

    localparam int N  = 8;
    localparam int AW = 4;

    logic          clk     = 1'b0;
    logic          reset   = 1'b0;
    logic          start   = 1'b0;
    logic          weCsd   = 1'b0;
    logic [AW-1:0] address = '0;
    logic [1:0]    dataIn  = '0;
    logic [N:0]    result;
    logic          busy;
    logic          done;
    logic          notCanonical;
    logic          illegalDigit;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [1:0] mem_m [N];

    always #5 clk = ~clk;

    csd_to_bin_decoder #(
        .N  (N),
        .AW (AW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .weCsd        (weCsd),
        .address      (address),
        .dataIn       (dataIn),
        .result       (result),
        .busy         (busy),
        .done         (done),
        .notCanonical (notCanonical),
        .illegalDigit (illegalDigit)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1);
    end

    // Value = sum of d_i * 2^i; non-canonical if any two neighbouring digits are non-zero.
    function automatic void model(output logic [N:0] val, output logic nc, output logic ill);
        int acc;
        int dv [N];
        acc = 0;
        nc  = 1'b0;
        ill = 1'b0;
        for (int i = 0; i < N; i++) begin
            dv[i] = (mem_m[i] == CSD_POS) ? 1 : (mem_m[i] == CSD_NEG) ? -1 : 0;
            if (mem_m[i] == CSD_ILL) ill = 1'b1;
            acc += dv[i] * (1 << i);
        end
        for (int i = 0; i < N - 1; i++) begin
            if (dv[i] != 0 && dv[i+1] != 0) nc = 1'b1;
        end
        val = (N + 1)'(acc);
    endfunction

    task automatic write_digit(input int a, input logic [1:0] code);
        @(negedge clk);
        weCsd   = 1'b1;
        address = AW'(a);
        dataIn  = code;
        @(negedge clk);
        weCsd = 1'b0;
        if (a < N) mem_m[a] = code;
    endtask

    task automatic decode(output logic [N:0] r, output logic nc, output logic ill,
                          output int lat, output int busy_cyc, output bit timed_out);
        @(negedge clk);
        start    = 1'b1;
        lat      = 0;
        busy_cyc = 0;
        do begin
            @(negedge clk);
            lat++;
            if (busy) busy_cyc++;
        end while (!done && lat < 4 * N);
        timed_out = !done;
        r   = result;
        nc  = notCanonical;
        ill = illegalDigit;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp += 5;
        if (result !== '0) begin
            n_err++; $display("FAIL reset_result: got %h want %h", result, 0);
        end
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL reset_busy: got %b want 0", busy);
        end
        if (done !== 1'b0) begin
            n_err++; $display("FAIL reset_done: got %b want 0", done);
        end
        if (notCanonical !== 1'b0) begin
            n_err++; $display("FAIL reset_nc: got %b want 0", notCanonical);
        end
        if (illegalDigit !== 1'b0) begin
            n_err++; $display("FAIL reset_ill: got %b want 0", illegalDigit);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    typedef struct {
        logic [2*N-1:0] codes;
        logic [N:0]     res;
        logic           nc;
        logic           ill;
    } vec_t;

    task automatic test_directed();
        vec_t       vecs [6];
        logic [N:0] r;
        logic       nc, ill;
        int         lat, bc;
        bit         to;
        vecs[0] = '{16'h4445, 9'd171,  1'b1, 1'b0};
        vecs[1] = '{16'h0043, 9'd7,    1'b0, 1'b0};
        vecs[2] = '{16'h0000, 9'd0,    1'b0, 1'b0};
        vecs[3] = '{16'h3333, 9'h1AB,  1'b0, 1'b0};
        vecs[4] = '{16'hFFFF, 9'h101,  1'b1, 1'b0};
        vecs[5] = '{16'h0420, 9'd32,   1'b0, 1'b1};
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < N; i++) write_digit(i, vecs[v].codes[2*i +: 2]);
            decode(r, nc, ill, lat, bc, to);
            n_cmp += 6;
            if (to) begin
                n_err++; $display("FAIL dir%0d_done: no done within %0d cycles", v, lat);
            end
            if (r !== vecs[v].res) begin
                n_err++; $display("FAIL dir%0d_result: got %h want %h", v, r, vecs[v].res);
            end
            if (nc !== vecs[v].nc) begin
                n_err++; $display("FAIL dir%0d_nc: got %b want %b", v, nc, vecs[v].nc);
            end
            if (ill !== vecs[v].ill) begin
                n_err++; $display("FAIL dir%0d_ill: got %b want %b", v, ill, vecs[v].ill);
            end
            if (lat != N + 1) begin
                n_err++; $display("FAIL dir%0d_latency: got %0d want %0d", v, lat, N + 1);
            end
            if (bc != N) begin
                n_err++; $display("FAIL dir%0d_busy_cycles: got %0d want %0d", v, bc, N);
            end
        end
    endtask

    task automatic test_random();
        logic [N:0] r, er;
        logic       nc, ill, enc, eill;
        int         lat, bc;
        bit         to;
        for (int it = 0; it < 20; it++) begin
            for (int i = 0; i < N; i++) begin
                // Leave some digits untouched so retained RAM contents get decoded too.
                if ($urandom_range(0, 3) != 0) write_digit(i, 2'($urandom_range(0, 3)));
            end
            model(er, enc, eill);
            decode(r, nc, ill, lat, bc, to);
            n_cmp += 3;
            if (to || r !== er) begin
                n_err++; $display("FAIL rnd%0d_result: got %h want %h", it, r, er);
            end
            if (nc !== enc) begin
                n_err++; $display("FAIL rnd%0d_nc: got %b want %b", it, nc, enc);
            end
            if (ill !== eill) begin
                n_err++; $display("FAIL rnd%0d_ill: got %b want %b", it, ill, eill);
            end
        end
    endtask

    task automatic test_write_during_run();
        logic [N:0] r, er;
        logic       nc, ill, enc, eill;
        int         lat, bc;
        bit         to;
        logic [1:0] alt;
        for (int i = 0; i < N; i++) write_digit(i, 2'($urandom_range(0, 3)));
        model(er, enc, eill);
        @(negedge clk);
        start = 1'b1;
        lat   = 0;
        do begin
            @(negedge clk);
            lat++;
            weCsd   = busy;
            address = (lat % 2 == 0) ? '0 : AW'($urandom_range(0, N - 1));
            dataIn  = ~mem_m[0];
        end while (!done && lat < 4 * N);
        weCsd = 1'b0;
        to    = !done;
        r     = result;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (to || r !== er) begin
            n_err++; $display("FAIL wrun_result: got %h want %h", r, er);
        end
        decode(r, nc, ill, lat, bc, to);
        n_cmp++;
        if (to || r !== er) begin
            n_err++; $display("FAIL wrun_rerun_result: got %h want %h", r, er);
        end
        alt = (mem_m[1] == CSD_POS) ? CSD_NEG : CSD_POS;
        write_digit(9, alt);
        write_digit(15, alt);
        model(er, enc, eill);
        decode(r, nc, ill, lat, bc, to);
        n_cmp += 2;
        if (to || r !== er) begin
            n_err++; $display("FAIL addr9_result: got %h want %h", r, er);
        end
        if (nc !== enc) begin
            n_err++; $display("FAIL addr9_nc: got %b want %b", nc, enc);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [N:0] r, er;
        logic       nc, ill, enc, eill;
        int         lat, bc, pulses;
        bit         to;
        for (int i = 0; i < N; i++) write_digit(i, (i % 2 == 0) ? CSD_POS : CSD_NEG);
        model(er, enc, eill);
        @(negedge clk);
        start = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        n_cmp += 3;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL midrst_state: got busy=%b done=%b want 0 0", busy, done);
        end
        if (result !== '0) begin
            n_err++; $display("FAIL midrst_result: got %h want %h", result, 0);
        end
        if (notCanonical !== 1'b0 || illegalDigit !== 1'b0) begin
            n_err++; $display("FAIL midrst_flags: got nc=%b ill=%b want 0 0",
                              notCanonical, illegalDigit);
        end
        pulses = 0;
        repeat (N + 3) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) pulses++;
        end
        n_cmp++;
        if (pulses != 0) begin
            n_err++; $display("FAIL midrst_no_done: got %0d active cycles want 0", pulses);
        end
        decode(r, nc, ill, lat, bc, to);
        n_cmp += 2;
        if (to || r !== er) begin
            n_err++; $display("FAIL midrst_rerun_result: got %h want %h", r, er);
        end
        if (nc !== enc) begin
            n_err++; $display("FAIL midrst_rerun_nc: got %b want %b", nc, enc);
        end
    endtask

    task automatic test_start_held();
        logic [N:0] er;
        logic       enc, eill;
        logic [1:0] code;
        int         lat, bad;
        for (int i = 0; i < N - 1; i++) write_digit(i, 2'($urandom_range(0, 3)));
        code = (mem_m[N-1] == CSD_NEG) ? CSD_POS : CSD_NEG;
        // Same-cycle write and start: the top digit must see the new value.
        @(negedge clk);
        start   = 1'b1;
        weCsd   = 1'b1;
        address = AW'(N - 1);
        dataIn  = code;
        mem_m[N-1] = code;
        model(er, enc, eill);
        @(negedge clk);
        weCsd = 1'b0;
        lat   = 1;
        while (!done && lat < 4 * N) begin
            @(negedge clk);
            lat++;
        end
        n_cmp += 2;
        if (done !== 1'b1 || result !== er) begin
            n_err++; $display("FAIL samecyc_result: got %h done=%b want %h", result, done, er);
        end
        if (lat != N + 1) begin
            n_err++; $display("FAIL samecyc_latency: got %0d want %0d", lat, N + 1);
        end
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (done !== 1'b1 || busy !== 1'b0 || result !== er) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++; $display("FAIL held_start: got %0d retrigger cycles want 0", bad);
        end
        start = 1'b0;
        @(negedge clk);
        n_cmp += 2;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL idle_return: got done=%b busy=%b want 0 0", done, busy);
        end
        if (result !== er) begin
            n_err++; $display("FAIL idle_result_hold: got %h want %h", result, er);
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) mem_m[i] = CSD_ZERO;
        test_reset();
        test_directed();
        test_random();
        test_write_during_run();
        test_reset_mid_run();
        test_start_held();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
